// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: op-class encodings,
// the hard-wired zero register, and the op-class decode helper.
// Reserved op-class 11 decodes as ALU so it never creates a pending entry.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    OPC_ALU  = 2'b00,
    OPC_LOAD = 2'b01,
    OPC_LONG = 2'b10,
    OPC_RSVD = 2'b11
  } op_class_e;

  localparam logic [4:0] REG_X0   = 5'd0;
  localparam int         NUM_REGS = 32;

  // Fold the reserved encoding onto ALU so downstream logic sees three classes.
  function automatic op_class_e decode_class(input logic [1:0] raw);
    op_class_e c;
    c = op_class_e'(raw);
    if (c == OPC_RSVD) c = OPC_ALU;
    return c;
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// Purpose: pending state for one architectural register (load countdown + long-op flag).
// Latency: set/clear take effect at the next rising edge; busy is purely registered.
// Backpressure: none; the parent decides when an issue fires.
//
// Ports:
//   clk, rst_n  - core clock, async active-low reset
//   set_load    - a load targeting this register fires: reload the countdown
//   set_long    - a long op targeting this register fires: raise the long flag
//   clr         - an ALU op targeting this register fires: value available next cycle
//   long_clr    - the long unit delivers this register's result
//   busy        - value not yet obtainable from the bypass network
//   long_pend   - a long op result is still outstanding
module scoreboard_entry #(
  parameter int CNT_W      = 2,
  parameter int LOAD_STALL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_load,
  input  logic set_long,
  input  logic clr,
  input  logic long_clr,
  output logic busy,
  output logic long_pend
);

  logic [CNT_W-1:0] cnt;
  logic             long_q;

  // An issue to this register takes priority over both the countdown and a
  // coincident long completion: the newer producer defines the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      long_q <= 1'b0;
    end else if (set_load) begin
      cnt    <= CNT_W'(LOAD_STALL);
      long_q <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      long_q <= 1'b0;
    end else if (set_long) begin
      cnt    <= '0;
      long_q <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      if (long_clr)  long_q <= 1'b0;
    end
  end

  assign busy      = (cnt != '0) || long_q;
  assign long_pend = long_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose: hold ID-stage instructions until their operands are bypassable and the long unit is free.
// Latency: stall is combinational from ID inputs and registered state; state updates on the next edge.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; flush_id overrides stall and kills the issue.
//
// Ports:
//   clk, rst_n            - core clock, async active-low reset
//   issue_valid           - valid instruction in ID
//   rs1_id, rs2_id        - source register specifiers; use_rs1/use_rs2 qualify them
//   rd_id, RegWrite_id    - destination and its write enable
//   op_class              - 00 ALU, 01 load, 10 long, 11 treated as ALU
//   flush_id              - kill the ID instruction this cycle
//   long_done, long_rd    - long unit completion and its destination
//   stall                 - hold ID this cycle
//   long_busy             - long unit occupied (registered)
//   pending_mask          - per-register unavailable flags (registered, bit 0 always 0)
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic [4:0]  rd_id,
  input  logic        RegWrite_id,
  input  logic [1:0]  op_class,
  input  logic        flush_id,
  input  logic        long_done,
  input  logic [4:0]  long_rd,
  output logic        stall,
  output logic        long_busy,
  output logic [31:0] pending_mask
);

  op_class_e   cls;
  logic        wr_en;
  logic        fire;
  logic        fire_wr;
  logic        raw_hit;
  logic        waw_hit;
  logic        struct_hit;
  logic [31:0] busy_vec;
  logic [31:0] long_vec;

  assign cls   = decode_class(op_class);
  assign wr_en = RegWrite_id && (rd_id != REG_X0);

  // x0 has no entry, so its slots read as permanently available.
  assign busy_vec[0] = 1'b0;
  assign long_vec[0] = 1'b0;

  assign raw_hit    = (use_rs1 && busy_vec[rs1_id]) || (use_rs2 && busy_vec[rs2_id]);
  assign waw_hit    = wr_en && long_vec[rd_id];
  // The long unit accepts a new op in the cycle it hands back the old result.
  assign struct_hit = (cls == OPC_LONG) && long_busy && !long_done;

  assign stall   = issue_valid && !flush_id && (raw_hit || waw_hit || struct_hit);
  assign fire    = issue_valid && !stall && !flush_id;
  assign fire_wr = fire && wr_en;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    logic hit;
    assign hit = fire_wr && (rd_id == 5'(i));

    scoreboard_entry #(
      .CNT_W      (CNT_W),
      .LOAD_STALL (LOAD_STALL)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_load  (hit && (cls == OPC_LOAD)),
      .set_long  (hit && (cls == OPC_LONG)),
      .clr       (hit && (cls == OPC_ALU)),
      .long_clr  (long_done && (long_rd == 5'(i))),
      .busy      (busy_vec[i]),
      .long_pend (long_vec[i])
    );
  end

  // A newly fired long op wins over a coincident completion of the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_busy <= 1'b0;
    end else if (fire_wr && (cls == OPC_LONG)) begin
      long_busy <= 1'b1;
    end else if (long_done) begin
      long_busy <= 1'b0;
    end
  end

  assign pending_mask = busy_vec;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side hazard tracker for the 5-stage core. It records every in-flight register write issued from ID, including its class (ALU, load, long-latency mul/div), and counts down or waits on completion. When an ID-stage consumer needs a value the MEM/WB bypass paths cannot yet supply, it raises `stall`. It works alongside the forwarding unit: that unit picks bypass sources for instructions already in EX, and this block holds instructions in ID until such a source exists.

## Interface
Parameters:
- `LOAD_STALL`, default 1: stall cycles a dependent consumer waits after a load issues (1..3).
- `CNT_W`, default 2: countdown width; must hold `LOAD_STALL`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `issue_valid`  in  1  valid instruction in ID.
- `rs1_id`, `rs2_id`  in  5 each  source register specifiers.
- `use_rs1`, `use_rs2`  in  1 each  instruction actually reads that source.
- `rd_id`  in  5  destination register.
- `RegWrite_id`  in  1  instruction writes `rd_id`.
- `op_class`  in  2  00 ALU, 01 load, 10 long, 11 reserved (treated as ALU).
- `flush_id`  in  1  kill the ID instruction this cycle.
- `long_done`  in  1  long unit delivers its result this cycle.
- `long_rd`  in  5  destination of the completing long op.
- `stall`  out  1  freeze PC and IF/ID; insert a bubble into ID/EX.
- `long_busy`  out  1  long unit occupied (registered).
- `pending_mask`  out  32  bit i is set while x(i) has an unavailable value (registered; bit 0 is always 0).

## Operation
- Per-register state for x1..x31: `cnt[CNT_W]` and a `long` flag. A register is unavailable when `cnt != 0` or `long` is set.
- Fire condition: `fire = issue_valid && !stall && !flush_id`.
- Effect of `fire` when `RegWrite_id` is set and `rd_id != 0`:
  - ALU: clear `cnt[rd]` and `long[rd]`.
  - Load: `cnt[rd] = LOAD_STALL`, clear `long[rd]`.
  - Long: set `long[rd]`, set `long_busy`.
- Every cycle, every nonzero `cnt` decrements by 1. A fire to the same register overrides the decrement.
- `long_done`: clears `long[long_rd]` and `long_busy`. If the same cycle fires a write to `long_rd`, the issue wins.
- `stall` is combinational and asserted when `issue_valid && !flush_id` and any of the following holds:
  - RAW: (`use_rs1` and rs1 is unavailable) or (`use_rs2` and rs2 is unavailable).
  - WAW: `RegWrite_id`, `rd_id != 0`, and `long[rd_id]` is set.
  - Structural: `op_class` is long and `long_busy` is set, unless `long_done` is asserted this cycle.
- A register read of x0 never stalls. Writes to x0 never change state.
- `flush_id` forces `stall = 0` and suppresses the fire.

## Timing
- Reset (async assert): all `cnt` = 0, all `long` = 0, `long_busy` = 0, `pending_mask` = 0. `stall` is therefore 0.
- Load fired at cycle t with `LOAD_STALL` = 1: a consumer in ID at t+1 stalls exactly 1 cycle and proceeds at t+2.
- Long op: consumers stall through the `long_done` cycle inclusive and are released the cycle after.
- A structural stall releases in the `long_done` cycle itself, so back-to-back long ops are allowed.
- `pending_mask` and `long_busy` reflect the state after the previous edge; there is no combinational path to them.
- Reset mid-operation clears all pending state immediately. A `long_done` arriving after reset is ignored, because `long[]` is already 0.

## Structure
- Add to `rtl/isa.v`:
  - `` `OPC_ALU ``, `` `OPC_LOAD ``, `` `OPC_LONG `` op-class encodings.
  - `` `REG_X0 ``.
- Sub-module `scoreboard_entry`: one register's `cnt`/`long` state, with inputs set_load, set_long, clr, long_clr and output busy. Instantiate it for x1..x31 with a generate loop.
- The top level holds the issue decode, `long_busy`, and the stall logic.

## Test plan
- Load x5 fired, next instruction `add x6,x5,x1` in ID → `stall` = 1 for 1 cycle, 0 on the following cycle; `pending_mask[5]` is 1 for 1 cycle.
- Load x5, then an instruction with `use_rs1` = 0 and rs1 = 5 → `stall` stays 0.
- Long op to x7, consumer of x7 waiting, `long_done` 6 cycles later → `stall` = 1 through the done cycle, 0 the next; `long_busy` drops the same edge.
- Second long op while busy → `stall` = 1; with `long_done` in the same cycle → `stall` = 0, and the new op fires with `long_busy` staying 1.
- ALU op writing x7 while long x7 is pending → WAW `stall` until release; a load to x0 → `pending_mask` stays 0.
- `flush_id` during a RAW stall → `stall` = 0, no fire. `rst_n` pulled low mid-long-op → `pending_mask` = 0 and `long_busy` = 0 asynchronously.
